// File: rtl/lif_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_tdm_scheduler
// Brief    : Four virtual leaky-integrate-and-fire neurons sharing a single
//            update datapath. Requests are granted round-robin, and every
//            update passes through IDLE -> CALC -> RESP, so at most one update
//            completes every three cycles.
//
// Ports    : clk         - single clock, rising edge
//            rst         - asynchronous active-high reset
//            in_valid    - [3:0] per-neuron update request
//            in_current  - [31:0] packed unsigned currents, neuron i at [8i+7:8i]
//            in_ready    - [3:0] one-hot accept for the round-robin winner (IDLE only)
//            out_valid   - one-cycle completion pulse (RESP)
//            out_id      - [1:0] neuron whose update completed
//            out_state   - [7:0] saturated membrane value before any spike reset
//            out_spike   - out_state >= THRESHOLD (and neuron not refractory)
//            busy        - FSM is not in IDLE
//
// Options  : LIF_REFRACTORY_EN - adds a per-neuron 2-bit refractory counter.
//            While the counter is nonzero, an update integrates zero current
//            and cannot spike.
//
// Revision : 1.0 - initial release
// ============================================================================
module lif_tdm_scheduler #(
    parameter logic [7:0] THRESHOLD      = 8'd200,
    parameter int         LEAK_SHIFT     = 1,
    parameter int         REFRAC_UPDATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_valid,
    input  logic [31:0] in_current,
    output logic [3:0]  in_ready,
    output logic        out_valid,
    output logic [1:0]  out_id,
    output logic [7:0]  out_state,
    output logic        out_spike,
    output logic        busy
);

    // Reject parameter values outside the legal range at elaboration time.
    if (LEAK_SHIFT < 0 || LEAK_SHIFT > 7 || REFRAC_UPDATES < 0 || REFRAC_UPDATES > 3) begin : g_param_check
        $error("lif_tdm_scheduler: LEAK_SHIFT must be 0..7 and REFRAC_UPDATES must be 0..3");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_mem [4];
    logic [1:0]  r_last_grant;
    logic [1:0]  r_id;
    logic [7:0]  r_cur;
    logic [1:0]  r_out_id;
    logic [7:0]  r_out_state;
    logic        r_out_spike;

    logic [3:0]  w_grant_oh;
    logic [1:0]  w_grant_id;
    logic        w_grant_found;
    logic [1:0]  w_idx;
    logic        w_accept;

    logic [7:0]  w_leak;
    logic [7:0]  w_cur_eff;
    logic [8:0]  w_sum;
    logic [7:0]  w_sat;
    logic        w_thresh_hit;
    logic        w_spike;

    // ------------------------------------------------------------------
    // Round-robin arbiter: search from last_grant+1 and wrap around. The
    // fourth step (k = 4) lands back on last_grant, so that neuron can win
    // again when it is the only requester.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_oh    = 4'b0000;
        w_grant_id    = r_last_grant;
        w_grant_found = 1'b0;
        w_idx         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_grant_found && in_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_idx;
            end
        end
        w_grant_oh[w_grant_id] = w_grant_found;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs. in_ready is gated with rst so
    // that no grant is shown while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 4'b0000;
        w_accept     = 1'b0;
        busy         = 1'b1;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    in_ready = w_grant_oh;
                end
                if (w_grant_found) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_state_next = RESP;
            end
            RESP: begin
                out_valid    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // LIF arithmetic. The leak is applied to the stored value, the captured
    // current is added in 9 bits, and the result saturates at 255.
    // ------------------------------------------------------------------
    assign w_leak       = r_mem[r_id] >> LEAK_SHIFT;
    assign w_sum        = {1'b0, w_leak} + {1'b0, w_cur_eff};
    assign w_sat        = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_thresh_hit = (w_sat >= THRESHOLD);

`ifdef LIF_REFRACTORY_EN
    logic [1:0] r_refrac [4];
    logic       w_refrac_active;

    assign w_refrac_active = (r_refrac[r_id] != 2'd0);
    assign w_cur_eff       = w_refrac_active ? 8'd0 : r_cur;
    assign w_spike         = w_thresh_hit & ~w_refrac_active;

    // While refractory, each update counts the counter down. A fresh spike
    // reloads it. The counter is only touched by the update that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_refrac[i] <= 2'd0;
            end
        end else if (r_state == CALC) begin
            if (w_refrac_active) begin
                r_refrac[r_id] <= r_refrac[r_id] - 2'd1;
            end else if (w_spike) begin
                r_refrac[r_id] <= 2'(REFRAC_UPDATES);
            end
        end
    end
`else
    assign w_cur_eff = r_cur;
    assign w_spike   = w_thresh_hit;
`endif

    // ------------------------------------------------------------------
    // Capture on accept, then commit the result on the CALC -> RESP edge.
    // A reset during CALC prevents that edge, so the update is discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 8'd0;
            end
            r_last_grant <= 2'd3;
            r_id         <= 2'd0;
            r_cur        <= 8'd0;
            r_out_id     <= 2'd0;
            r_out_state  <= 8'd0;
            r_out_spike  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id         <= w_grant_id;
                r_cur        <= in_current[{w_grant_id, 3'b000} +: 8];
                r_last_grant <= w_grant_id;
            end
            if (r_state == CALC) begin
                r_mem[r_id] <= w_spike ? 8'd0 : w_sat;
                r_out_id    <= r_id;
                r_out_state <= w_sat;
                r_out_spike <= w_spike;
            end
        end
    end

    assign out_id    = r_out_id;
    assign out_state = r_out_state;
    assign out_spike = r_out_spike;

endmodule
`default_nettype wire

// File: tb/tb_lif_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_tdm_scheduler
// Brief    : Self-checking bench for lif_tdm_scheduler. A behavioural neuron
//            model is checked against the DUT on every falling edge, and
//            directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_tdm_scheduler;

    localparam int TH    = 200;
    localparam int LEAK  = 1;
    localparam int REFR  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = 4'b0000;
    logic [31:0] in_current = 32'd0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [1:0]  out_id;
    logic [7:0]  out_state;
    logic        out_spike;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    lif_tdm_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_current (in_current),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_state  (out_state),
        .out_spike  (out_spike),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. m_cnt is the number of cycles left before the
    // block is idle again: 2 = computing, 1 = result presented.
    // ------------------------------------------------------------------
    int m_mem [4];
    int m_ref [4];
    int m_last = 3;
    int m_cnt  = 0;
    int m_pid  = 0;
    int m_pcur = 0;
    int h_id = 0, h_state = 0, h_spike = 0;

    always @(negedge clk) begin
        int exp_ready;
        int win;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_mem[i] = 0;
                m_ref[i] = 0;
            end
            m_last = 3; m_cnt = 0;
            h_id = 0; h_state = 0; h_spike = 0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_state", out_state, 0);
            chk("rst_out_spike", out_spike, 0);
            chk("rst_out_id", out_id, 0);
        end else begin
            exp_ready = 0;
            win = -1;
            if (m_cnt == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (win < 0 && in_valid[(m_last + k) % 4]) win = (m_last + k) % 4;
                end
                if (win >= 0) exp_ready = 1 << win;
            end
            chk("in_ready", in_ready, exp_ready);
            chk("busy", busy, (m_cnt != 0) ? 1 : 0);
            chk("out_valid", out_valid, (m_cnt == 1) ? 1 : 0);
            chk("out_id", out_id, h_id);
            chk("out_state", out_state, h_state);
            chk("out_spike", out_spike, h_spike);
            // Advance to the next rising edge.
            if (m_cnt == 2) begin
                int leak, cur, sum, spk;
                leak = m_mem[m_pid] / (1 << LEAK);
                cur  = m_pcur;
`ifdef LIF_REFRACTORY_EN
                if (m_ref[m_pid] > 0) cur = 0;
`endif
                sum = leak + cur;
                if (sum > 255) sum = 255;
                spk = (sum >= TH) ? 1 : 0;
`ifdef LIF_REFRACTORY_EN
                if (m_ref[m_pid] > 0) begin
                    spk = 0;
                    m_ref[m_pid] = m_ref[m_pid] - 1;
                end else if (spk == 1) begin
                    m_ref[m_pid] = REFR;
                end
`endif
                m_mem[m_pid] = (spk == 1) ? 0 : sum;
                h_id = m_pid; h_state = sum; h_spike = spk;
            end
            if (m_cnt > 0) begin
                m_cnt--;
            end else if (win >= 0) begin
                m_pid  = win;
                m_pcur = (in_current >> (8 * win)) & 255;
                m_last = win;
                m_cnt  = 2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Single update with literal expectations on result and latency. After
    // the accept edge, the request is dropped and the currents are
    // scrambled; the captured value must survive that.
    task automatic update(input int id, input logic [7:0] cur,
                          input int es, input int esp, input string tag);
        int n;
        @(posedge clk); #1;
        in_valid   = 4'(1 << id);
        in_current = 32'd0;
        in_current[id*8 +: 8] = cur;
        n = 0;
        @(negedge clk);
        while (!in_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({tag, "_accept_timeout"}, 1, 0);
        @(posedge clk); #1;
        in_valid   = 4'b0000;
        in_current = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({tag, "_calc_no_valid"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_id"}, out_id, id);
        chk({tag, "_state"}, out_state, es);
        chk({tag, "_spike"}, out_spike, esp);
    endtask

    initial begin
        int gid [6];
        int gcyc [6];
        int exp_g [6];
        int ng;
        exp_g = '{0, 1, 2, 3, 0, 1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Neuron 0 integration, spike and reset to zero.
        update(0, 8'd100, 100, 0, "n0_a");
        update(0, 8'd100, 150, 0, "n0_b");
        update(0, 8'd150, 225, 1, "n0_c");
        update(0, 8'd0,   0,   0, "n0_zero");

        // Neuron 1 saturation.
        update(1, 8'd150, 150, 0, "n1_pre");
        update(1, 8'd255, 255, 1, "n1_sat");
        update(1, 8'd40,  40,  0, "n1_after");

        // Round-robin with all requests held.
        do_reset();
        in_valid   = 4'hF;
        in_current = {8'd4, 8'd3, 8'd2, 8'd1};
        ng = 0;
        for (int c = 0; c < 30 && ng < 6; c++) begin
            @(negedge clk);
            if (in_ready != 4'b0000) begin
                gid[ng]  = (in_ready == 4'b0001) ? 0 : (in_ready == 4'b0010) ? 1 :
                           (in_ready == 4'b0100) ? 2 : (in_ready == 4'b1000) ? 3 : 9;
                gcyc[ng] = c;
                ng++;
            end
        end
        @(posedge clk); #1;
        in_valid = 4'b0000;
        chk("rr_grant_count", ng, 6);
        for (int i = 0; i < ng; i++) begin
            chk("rr_grant_id", gid[i], exp_g[i]);
            if (i > 0) chk("rr_grant_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        repeat (4) @(posedge clk);

        // Reset during CALC aborts the neuron 2 update.
        do_reset();
        in_valid   = 4'b0100;
        in_current = {8'd0, 8'd50, 8'd0, 8'd0};
        @(negedge clk);
        chk("abort_grant", in_ready, 4'b0100);
        @(posedge clk); #2;
        chk("abort_in_calc", busy, 1);
        rst = 1'b1;
        in_valid = 4'b0000;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 4'b0101;
        @(negedge clk);
        chk("abort_next_grant", in_ready, 4'b0001);
        @(posedge clk); #1;
        in_valid = 4'b0000;
        repeat (3) @(posedge clk);
        update(2, 8'd10, 10, 0, "n2_after_abort");

        // Neuron 3: refractory behaviour.
        do_reset();
        update(3, 8'd255, 255, 1, "n3_spk");
`ifdef LIF_REFRACTORY_EN
        update(3, 8'd255, 0,   0, "n3_r1");
        update(3, 8'd255, 0,   0, "n3_r2");
        update(3, 8'd255, 255, 1, "n3_r3");
`else
        update(3, 8'd255, 255, 1, "n3_r1");
        update(3, 8'd255, 255, 1, "n3_r2");
        update(3, 8'd255, 255, 1, "n3_r3");
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
